rl_ram_1r1w_ext: RTL and testbench
==================================

// Module: rl_ram_1r1w_ext
// PURPOSE
//  Parametrised 1R1W inferrable RAM with configurable byte-lane width, read-enable, 1- or 2-cycle read
//  latency, selectable read-during-write bypass and a post-reset clear engine that fills the array
//  with INIT_VALUE. Used for register files, caches and FIFOs that need deterministic contents after reset.
// PARAMETERS
//  ABITS       10  address bits; depth = 2**ABITS
//  DBITS       32  data bits
//  BYTEW       8   lane width; LANES = (DBITS+BYTEW-1)/BYTEW; last lane may be narrower
//  RD_LATENCY  1   1 or 2 cycles from re_i to dout_valid_o
//  BYPASS      1   1: same-address collision returns new data per enabled lane; 0: returns old data
//  INIT_CLEAR  1   1: clear engine runs after reset; 0: no clear, contents undefined
//  INIT_VALUE  '0  DBITS-wide fill value
// PORTS
//  clk_i         in   1      clock, rising edge
//  rst_i         in   1      reset, synchronous, active-high
//  waddr_i       in   ABITS  write address
//  din_i         in   DBITS  write data
//  we_i          in   1      write enable
//  be_i          in   LANES  lane enables, qualified by we_i
//  raddr_i       in   ABITS  read address
//  re_i          in   1      read enable
//  dout_o        out  DBITS  read data; holds between reads
//  dout_valid_o  out  1      one-cycle pulse per accepted read
//  busy_o        out  1      clear engine active; all requests ignored
// BEHAVIOUR
//  - Reset: dout_o=0, dout_valid_o=0, read pipeline flushed. INIT_CLEAR=1: state ST_CLEAR, busy_o=1,
//    clear counter=0. INIT_CLEAR=0: state ST_READY, busy_o=0.
//  - ST_CLEAR: one word per cycle, mem[cnt]<=INIT_VALUE (all lanes), cnt++. On cnt==2**ABITS-1,
//    -> ST_READY; busy_o drops the cycle after the last write (exactly 2**ABITS busy cycles after rst_i low).
//  - While busy_o=1: we_i/re_i dropped, not queued; dout_valid_o=0.
//  - rst_i asserted mid-clear restarts the counter at 0. Mid-read: in-flight reads discarded, no valid pulse.
//  - Write (ST_READY): we_i&&be_i[l] updates lane l at waddr_i at the clock edge; be_i=0 = no-op.
//  - Read: re_i at edge N -> dout_o/dout_valid_o at edge N+RD_LATENCY. Fully pipelined, one read per cycle.
//    Stages load only when their valid bit is set; dout_o otherwise holds.
//  - Collision (we_i&&re_i, waddr_i==raddr_i, same cycle): BYPASS=1 -> enabled lanes return din_i,
//    others return stored data. BYPASS=0 -> all lanes return pre-write data. Later reads see new data.
//    Bypass implemented by registering hit flag, lane mask and din_i alongside the array read and merging
//    after stage 1. Array read path never has write-to-read bypass.
//  - Partial last lane: lane LANES-1 covers bits [DBITS-1:(LANES-1)*BYTEW].
//  - RD_LATENCY outside {1,2} or BYTEW<1: elaboration-time $error.
// STRUCTURE
//  - Package rl_ram_pkg: typedef enum {ST_CLEAR, ST_READY} ram_state_t; function lanes(dbits, bytew).
//  - Sub-module rl_ram_1r1w_core (ABITS, DBITS, BYTEW): lane-masked inferrable array, registered read,
//    no reset on array. Top holds clear FSM/counter, write-port mux (clear vs user), bypass merge,
//    optional stage-2 register and valid pipeline.
// TESTING (ABITS=4, DBITS=32, BYTEW=8 unless stated)
//  1. INIT_VALUE=32'hA5A5_A5A5, release rst_i -> busy_o high exactly 16 cycles; read addr 7 -> A5A5_A5A5
//     with dout_valid_o 1 cycle later.
//  2. INIT_VALUE=0; write addr 3 din 32'h1122_3344 be 4'b0101; read addr 3 -> 32'h0022_0044.
//  3. mem[5]=FFFF_FFFF; same cycle we addr 5 din 1234_5678 be 4'b0011 + re addr 5 -> BYPASS=1: FFFF_5678,
//     BYPASS=0: FFFF_FFFF; next read addr 5 -> FFFF_5678 in both modes.
//  4. RD_LATENCY=2; reads addr 0,1,2,3 back-to-back -> four consecutive valid pulses, in order, starting
//     2 cycles after first re_i; dout_o holds addr-3 data afterwards.
//  5. Reassert rst_i at clear cycle 6; write addr 2 during busy -> busy_o 16 cycles after second release;
//     addr 2 reads INIT_VALUE; re_i during busy gives no valid pulse.
//  6. DBITS=36 (LANES=5, lane 4 = 4 bits); write addr 1 din 36'hF_0000_0000 be 5'b10000 onto zeroed
//     array -> read 36'hF_0000_0000.

Source files
------------

// File: rtl/rl_ram_pkg.sv
// Shared types and helpers for the rl_ram_1r1w family.
package rl_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  // Number of byte lanes; the last lane may be narrower than bytew.
  function automatic int unsigned lanes(input int unsigned dbits, input int unsigned bytew);
    if (bytew == 0) return 1;
    return (dbits + bytew - 1) / bytew;
  endfunction

endpackage

// File: rtl/rl_ram_1r1w_core.sv
// Lane-masked 1R1W array with a registered read port; the array itself has no reset.
module rl_ram_1r1w_core
  import rl_ram_pkg::*;
#(
  parameter int unsigned ABITS = 10,
  parameter int unsigned DBITS = 32,
  parameter int unsigned BYTEW = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            we_i,
  input  logic [lanes(DBITS, BYTEW)-1:0]  be_i,
  input  logic [ABITS-1:0]                waddr_i,
  input  logic [DBITS-1:0]                din_i,
  input  logic                            re_i,
  input  logic [ABITS-1:0]                raddr_i,
  output logic [DBITS-1:0]                rdata_o
);

  localparam int unsigned DEPTH = 2 ** ABITS;
  localparam int unsigned LW    = (BYTEW < 1) ? 1 : BYTEW;

  logic [DBITS-1:0] r_mem [DEPTH];
  logic [DBITS-1:0] r_rdata;
  logic [DBITS-1:0] w_bmask;

  for (genvar b = 0; b < int'(DBITS); b++) begin : g_bmask
    assign w_bmask[b] = be_i[b / LW];
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= (r_mem[waddr_i] & ~w_bmask) | (din_i & w_bmask);
    end
  end

  // Read returns pre-write contents on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (re_i) begin
      r_rdata <= r_mem[raddr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/rl_ram_1r1w_ext.sv
// 1R1W RAM with lane enables, 1/2-cycle read latency, optional collision bypass
// and a post-reset clear engine.
module rl_ram_1r1w_ext
  import rl_ram_pkg::*;
#(
  parameter int unsigned      ABITS      = 10,
  parameter int unsigned      DBITS      = 32,
  parameter int unsigned      BYTEW      = 8,
  parameter int unsigned      RD_LATENCY = 1,
  parameter int unsigned      BYPASS     = 1,
  parameter int unsigned      INIT_CLEAR = 1,
  parameter logic [DBITS-1:0] INIT_VALUE = '0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [ABITS-1:0]                waddr_i,
  input  logic [DBITS-1:0]                din_i,
  input  logic                            we_i,
  input  logic [lanes(DBITS, BYTEW)-1:0]  be_i,
  input  logic [ABITS-1:0]                raddr_i,
  input  logic                            re_i,
  output logic [DBITS-1:0]                dout_o,
  output logic                            dout_valid_o,
  output logic                            busy_o
);

  localparam int unsigned LANES = lanes(DBITS, BYTEW);
  localparam int unsigned LW    = (BYTEW < 1) ? 1 : BYTEW;
  localparam logic [ABITS-1:0] CNT_LAST = '1;
  localparam ram_state_t ST_RESET = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("rl_ram_1r1w_ext: RD_LATENCY must be 1 or 2");
  end
  if (BYTEW < 1) begin : g_bad_bytew
    $error("rl_ram_1r1w_ext: BYTEW must be at least 1");
  end

  ram_state_t       r_state, w_state_nxt;
  logic [ABITS-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == ST_CLEAR) begin
      w_cnt_nxt = r_cnt + ABITS'(1);
      if (r_cnt == CNT_LAST) begin
        w_state_nxt = ST_READY;
      end
    end
  end

  logic             w_busy, w_we, w_re, w_hit;
  logic [LANES-1:0] w_be;
  logic [ABITS-1:0] w_waddr;
  logic [DBITS-1:0] w_wdata, w_arr;

  // Clear engine owns the write port while busy; user traffic is dropped.
  assign w_busy  = (r_state == ST_CLEAR);
  assign w_we    = w_busy | (we_i & ~rst_i);
  assign w_be    = w_busy ? '1 : be_i;
  assign w_waddr = w_busy ? r_cnt : waddr_i;
  assign w_wdata = w_busy ? INIT_VALUE : din_i;
  assign w_re    = re_i & ~w_busy & ~rst_i;
  assign w_hit   = (BYPASS != 0) & w_re & we_i & (|be_i) & (waddr_i == raddr_i);

  rl_ram_1r1w_core #(
    .ABITS (ABITS),
    .DBITS (DBITS),
    .BYTEW (BYTEW)
  ) u_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (w_we),
    .be_i    (w_be),
    .waddr_i (w_waddr),
    .din_i   (w_wdata),
    .re_i    (w_re),
    .raddr_i (raddr_i),
    .rdata_o (w_arr)
  );

  logic             r_v1, r_hit;
  logic [LANES-1:0] r_hit_be;
  logic [DBITS-1:0] r_hit_din, w_hit_mask, w_s1;

  // Collision info travels alongside the array read and is merged after stage 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v1      <= 1'b0;
      r_hit     <= 1'b0;
      r_hit_be  <= '0;
      r_hit_din <= '0;
    end else begin
      r_v1 <= w_re;
      if (w_re) begin
        r_hit     <= w_hit;
        r_hit_be  <= be_i;
        r_hit_din <= din_i;
      end
    end
  end

  for (genvar b = 0; b < int'(DBITS); b++) begin : g_hit_mask
    assign w_hit_mask[b] = r_hit_be[b / LW];
  end

  assign w_s1 = r_hit ? ((w_arr & ~w_hit_mask) | (r_hit_din & w_hit_mask)) : w_arr;

  if (RD_LATENCY == 2) begin : g_lat2
    logic             r_v2;
    logic [DBITS-1:0] r_dout2;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_v2    <= 1'b0;
        r_dout2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_dout2 <= w_s1;
        end
      end
    end

    assign dout_o       = r_dout2;
    assign dout_valid_o = r_v2;
  end else begin : g_lat1
    assign dout_o       = w_s1;
    assign dout_valid_o = r_v1;
  end

  assign busy_o = w_busy;

endmodule

// File: tb/tb_rl_ram_1r1w_ext.sv
// Scoreboard bench for rl_ram_1r1w_ext: five instances cover clear fill, no-clear,
// lane writes, collision bypass modes, 2-cycle latency and a 36-bit partial lane.
module tb_rl_ram_1r1w_ext;

  logic clk;
  logic rst;

  // Instance map: 0=A5 fill/bypass/lat1, 1=no bypass, 2=lat2, 3=no clear, 4=36-bit
  logic        we    [5];
  logic        re    [5];
  logic [3:0]  waddr [5];
  logic [3:0]  raddr [5];
  logic [35:0] din   [5];
  logic [4:0]  be    [5];
  logic        valid [5];
  logic        busy  [5];
  logic [31:0] dout32 [4];
  logic [35:0] dout_d;
  logic [35:0] obs   [5];

  logic [35:0] exp_q [5][$];
  logic [35:0] mon_exp;
  int checks;
  int errors;

  rl_ram_1r1w_ext #(.ABITS(4), .DBITS(32), .BYTEW(8), .RD_LATENCY(1), .BYPASS(1),
                    .INIT_CLEAR(1), .INIT_VALUE(32'hA5A5_A5A5)) u_a (
    .clk_i(clk), .rst_i(rst), .waddr_i(waddr[0]), .din_i(din[0][31:0]), .we_i(we[0]),
    .be_i(be[0][3:0]), .raddr_i(raddr[0]), .re_i(re[0]), .dout_o(dout32[0]),
    .dout_valid_o(valid[0]), .busy_o(busy[0]));

  rl_ram_1r1w_ext #(.ABITS(4), .DBITS(32), .BYTEW(8), .RD_LATENCY(1), .BYPASS(0),
                    .INIT_CLEAR(1), .INIT_VALUE(32'h0)) u_b (
    .clk_i(clk), .rst_i(rst), .waddr_i(waddr[1]), .din_i(din[1][31:0]), .we_i(we[1]),
    .be_i(be[1][3:0]), .raddr_i(raddr[1]), .re_i(re[1]), .dout_o(dout32[1]),
    .dout_valid_o(valid[1]), .busy_o(busy[1]));

  rl_ram_1r1w_ext #(.ABITS(4), .DBITS(32), .BYTEW(8), .RD_LATENCY(2), .BYPASS(1),
                    .INIT_CLEAR(1), .INIT_VALUE(32'h0)) u_c (
    .clk_i(clk), .rst_i(rst), .waddr_i(waddr[2]), .din_i(din[2][31:0]), .we_i(we[2]),
    .be_i(be[2][3:0]), .raddr_i(raddr[2]), .re_i(re[2]), .dout_o(dout32[2]),
    .dout_valid_o(valid[2]), .busy_o(busy[2]));

  rl_ram_1r1w_ext #(.ABITS(4), .DBITS(32), .BYTEW(8), .RD_LATENCY(1), .BYPASS(1),
                    .INIT_CLEAR(0), .INIT_VALUE(32'h0)) u_e (
    .clk_i(clk), .rst_i(rst), .waddr_i(waddr[3]), .din_i(din[3][31:0]), .we_i(we[3]),
    .be_i(be[3][3:0]), .raddr_i(raddr[3]), .re_i(re[3]), .dout_o(dout32[3]),
    .dout_valid_o(valid[3]), .busy_o(busy[3]));

  rl_ram_1r1w_ext #(.ABITS(4), .DBITS(36), .BYTEW(8), .RD_LATENCY(1), .BYPASS(1),
                    .INIT_CLEAR(1), .INIT_VALUE(36'h0)) u_d (
    .clk_i(clk), .rst_i(rst), .waddr_i(waddr[4]), .din_i(din[4]), .we_i(we[4]),
    .be_i(be[4]), .raddr_i(raddr[4]), .re_i(re[4]), .dout_o(dout_d),
    .dout_valid_o(valid[4]), .busy_o(busy[4]));

  assign obs[0] = {4'h0, dout32[0]};
  assign obs[1] = {4'h0, dout32[1]};
  assign obs[2] = {4'h0, dout32[2]};
  assign obs[3] = {4'h0, dout32[3]};
  assign obs[4] = dout_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every valid pulse must match the oldest outstanding expected read.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (valid[i] === 1'b1) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL rd_data inst%0d: got valid with dout %h, expected no valid", i, obs[i]);
        end else begin
          mon_exp = exp_q[i].pop_front();
          if (obs[i] !== mon_exp) begin
            errors++;
            $display("FAIL rd_data inst%0d: got %h, expected %h", i, obs[i], mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic set_wr(input int i, input logic [3:0] a, input logic [35:0] d, input logic [4:0] b);
    we[i] = 1'b1; waddr[i] = a; din[i] = d; be[i] = b;
  endtask

  task automatic set_rd(input int i, input logic [3:0] a, input logic [35:0] e);
    re[i] = 1'b1; raddr[i] = a;
    exp_q[i].push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      we[i] = 1'b0;
      re[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (dout32[0] !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h, expected 0", dout32[0]); end
    checks++;
    if (valid[0] !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid[0]); end
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL reset_busy_clear: got %b, expected 1", busy[0]); end
    checks++;
    if (busy[3] !== 1'b0) begin errors++; $display("FAIL reset_busy_noclear: got %b, expected 0", busy[3]); end
    checks++;
    if (dout32[2] !== 32'h0) begin errors++; $display("FAIL reset_dout_lat2: got %h, expected 0", dout32[2]); end
  endtask

  task automatic test_clear_fill();
    int n;
    rst = 1'b0;
    n = 0;
    while (busy[0] === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL clear_busy_cycles: got %0d, expected 16", n); end
    checks++;
    if (busy[4] !== 1'b0) begin errors++; $display("FAIL clear_busy_wide: got %b, expected 0", busy[4]); end
    set_rd(0, 4'd7, 36'h0_A5A5_A5A5);
    step();
    checks++;
    if (valid[0] !== 1'b1) begin errors++; $display("FAIL clear_read_latency: got valid %b, expected 1", valid[0]); end
    set_rd(0, 4'd15, 36'h0_A5A5_A5A5);
    step();
    step();
  endtask

  task automatic test_no_clear();
    set_wr(3, 4'd9, 36'h0_DEAD_BEEF, 5'h0F);
    step();
    set_rd(3, 4'd9, 36'h0_DEAD_BEEF);
    step();
    step();
  endtask

  task automatic test_lane_write();
    set_wr(1, 4'd3, 36'h0_1122_3344, 5'b00101);
    step();
    set_wr(1, 4'd3, 36'h0_FFFF_FFFF, 5'b00000);
    step();
    set_rd(1, 4'd3, 36'h0_0022_0044);
    step();
    step();
    checks++;
    if (dout32[1] !== 32'h0022_0044 || valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL lane_hold: got dout %h valid %b, expected 00220044 valid 0", dout32[1], valid[1]);
    end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 3; i++) set_wr(i, 4'd5, 36'h0_FFFF_FFFF, 5'h0F);
    step();
    for (int i = 0; i < 3; i++) set_wr(i, 4'd5, 36'h0_1234_5678, 5'b00011);
    set_rd(0, 4'd5, 36'h0_FFFF_5678);
    set_rd(1, 4'd5, 36'h0_FFFF_FFFF);
    set_rd(2, 4'd5, 36'h0_FFFF_5678);
    step();
    for (int i = 0; i < 3; i++) set_rd(i, 4'd5, 36'h0_FFFF_5678);
    step();
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      set_wr(2, 4'(k), 36'h0_C0DE_0000 + 36'(k), 5'h0F);
      step();
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (valid[2] !== ((k >= 2 && k <= 5) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL lat2_valid_k%0d: got %b, expected %b", k, valid[2], (k >= 2 && k <= 5));
      end
      if (k < 4) set_rd(2, 4'(k), 36'h0_C0DE_0000 + 36'(k));
      else re[2] = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (dout32[2] !== 32'hC0DE_0003) begin errors++; $display("FAIL lat2_hold: got %h, expected c0de0003", dout32[2]); end
  endtask

  task automatic test_wide_lane();
    set_wr(4, 4'd1, 36'hF_0000_0000, 5'b10000);
    step();
    set_rd(4, 4'd1, 36'hF_0000_0000);
    step();
    set_wr(4, 4'd1, 36'h0_1234_5678, 5'b01111);
    step();
    set_rd(4, 4'd1, 36'hF_1234_5678);
    step();
    step();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    re[2] = 1'b1; raddr[2] = 4'd3;
    @(negedge clk);
    re[2] = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (valid[2] !== 1'b0) begin errors++; $display("FAIL flush_inflight: got valid %b, expected 0", valid[2]); end
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL midclear_busy: got %b, expected 1", busy[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    we[0] = 1'b1; waddr[0] = 4'd2; din[0] = 36'h0_0BAD_F00D; be[0] = 5'h0F;
    re[0] = 1'b1; raddr[0] = 4'd2;
    n = 0;
    while (busy[0] === 1'b1 && n < 40) begin
      n++;
      checks++;
      if (valid[0] !== 1'b0) begin errors++; $display("FAIL busy_valid: got %b, expected 0", valid[0]); end
      @(negedge clk);
    end
    we[0] = 1'b0;
    re[0] = 1'b0;
    checks++;
    if (n != 16) begin errors++; $display("FAIL restart_busy_cycles: got %0d, expected 16", n); end
    set_rd(0, 4'd2, 36'h0_A5A5_A5A5);
    step();
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      we[i] = 1'b0; re[i] = 1'b0; waddr[i] = '0; raddr[i] = '0; din[i] = '0; be[i] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_clear_fill();
    test_no_clear();
    test_lane_write();
    test_collision();
    test_back_to_back();
    test_wide_lane();
    test_reset_mid_clear();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL missing_reads inst%0d: got %0d outstanding, expected 0", i, exp_q[i].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
